// File: rtl/conv3x3_filter.sv
// 3x3 colour convolution filter with two line buffers per channel and a fixed 2-cycle latency.
// The mode is latched per frame at pixel (0,0); sat_count counts sharpen clamp events per frame.
module conv3x3_filter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int PW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          de_in,
    input  logic [9:0]    x_in,
    input  logic [9:0]    y_in,
    input  logic [PW-1:0] r_in,
    input  logic [PW-1:0] g_in,
    input  logic [PW-1:0] b_in,
    input  logic [1:0]    mode_cfg,
    output logic          de_out,
    output logic [9:0]    x_out,
    output logic [9:0]    y_out,
    output logic [PW-1:0] r_out,
    output logic [PW-1:0] g_out,
    output logic [PW-1:0] b_out,
    output logic [1:0]    mode_active,
    output logic [15:0]   sat_count
);
    localparam int AW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int CW = 3 * PW;
    localparam logic [9:0] HMAX = 10'(H_RES);
    localparam logic [9:0] VMAX = 10'(V_RES);

    typedef enum logic [1:0] {
        M_BYPASS = 2'b00,
        M_GAUSS  = 2'b01,
        M_BOX    = 2'b10,
        M_SHARP  = 2'b11
    } mode_e;

    logic [CW-1:0]   line0_q [H_RES];
    logic [CW-1:0]   line1_q [H_RES];
    logic [CW-1:0]   win_q [3][3];   // [row][col]; row 0 = oldest line, col 2 = newest pixel
    logic [CW-1:0]   pix_in;
    logic [AW-1:0]   xa;
    logic            img, origin;

    logic            de1_q, filt1_q;
    logic [9:0]      x1_q, y1_q;
    logic [CW-1:0]   pix1_q;

    logic            de_q, de_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic [CW-1:0]   pix_q, pix_d;
    mode_e           mode_q, mode_d;
    logic [15:0]     sat_q, sat_d;
    logic            clamp;
    logic [PW:0]     res;
    logic [9*PW-1:0] wv [3];

    assign pix_in = {r_in, g_in, b_in};
    assign xa     = x_in[AW-1:0];
    assign img    = de_in && (x_in < HMAX) && (y_in < VMAX);
    assign origin = img && (x_in == '0) && (y_in == '0);

    // Returns {clamped, value}; clamping can only occur in sharpen mode.
    function automatic logic [PW:0] kern(input logic [9*PW-1:0] w, input mode_e m);
        logic [PW+3:0]        e [9];
        logic signed [PW+4:0] se [9];
        logic [PW+3:0]        s;
        logic signed [PW+4:0] t;
        logic signed [PW+4:0] maxv;
        for (int unsigned k = 0; k < 9; k++) begin
            e[k]  = {4'b0, w[k*PW +: PW]};
            se[k] = signed'({5'b0, w[k*PW +: PW]});
        end
        s    = '0;
        t    = '0;
        maxv = signed'({5'b0, {PW{1'b1}}});
        kern = '0;
        case (m)
            M_GAUSS: begin
                s = e[0] + (e[1] << 1) + e[2] + (e[3] << 1) + (e[4] << 2)
                  + (e[5] << 1) + e[6] + (e[7] << 1) + e[8];
                kern = {1'b0, s[PW+3:4]};
            end
            M_BOX: begin
                s = e[0] + e[1] + e[2] + e[3] + (e[4] << 3) + e[5] + e[6] + e[7] + e[8];
                kern = {1'b0, s[PW+3:4]};
            end
            M_SHARP: begin
                t = (se[4] <<< 2) + se[4] - se[1] - se[3] - se[5] - se[7];
                if (t[PW+4])      kern = {1'b1, {PW{1'b0}}};
                else if (t > maxv) kern = {1'b1, {PW{1'b1}}};
                else               kern = {1'b0, t[PW-1:0]};
            end
            default: kern = '0;
        endcase
    endfunction

    // Line buffers carry no reset; only rows written in the current frame are ever used.
    always_ff @(posedge clk) begin
        if (img) begin
            line0_q[xa] <= line1_q[xa];
            line1_q[xa] <= pix_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < 3; r++)
                for (int unsigned c = 0; c < 3; c++)
                    win_q[r][c] <= '0;
            de1_q   <= 1'b0;
            filt1_q <= 1'b0;
            x1_q    <= '0;
            y1_q    <= '0;
            pix1_q  <= '0;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= '0;
            mode_q  <= M_BYPASS;
            sat_q   <= '0;
        end else begin
            if (img) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    win_q[r][0] <= (x_in == '0) ? '0 : win_q[r][1];
                    win_q[r][1] <= (x_in == '0) ? '0 : win_q[r][2];
                end
                win_q[0][2] <= line0_q[xa];
                win_q[1][2] <= line1_q[xa];
                win_q[2][2] <= pix_in;
            end
            de1_q   <= de_in;
            filt1_q <= img && (x_in >= 10'd2) && (y_in >= 10'd2);
            x1_q    <= x_in;
            y1_q    <= y_in;
            pix1_q  <= pix_in;
            de_q    <= de_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pix_q   <= pix_d;
            mode_q  <= mode_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        for (int unsigned ch = 0; ch < 3; ch++) begin
            wv[ch] = '0;
            for (int unsigned r = 0; r < 3; r++)
                for (int unsigned c = 0; c < 3; c++)
                    wv[ch][(r*3+c)*PW +: PW] = win_q[r][c][ch*PW +: PW];
        end
    end

    always_comb begin
        de_d  = de1_q;
        x_d   = '0;
        y_d   = '0;
        pix_d = '0;
        clamp = 1'b0;
        res   = '0;
        if (de1_q) begin
            x_d   = x1_q;
            y_d   = y1_q;
            pix_d = pix1_q;
            if (filt1_q && (mode_q != M_BYPASS)) begin
                for (int unsigned ch = 0; ch < 3; ch++) begin
                    res = kern(wv[ch], mode_q);
                    pix_d[ch*PW +: PW] = res[PW-1:0];
                    clamp = clamp | res[PW];
                end
            end
        end
    end

    always_comb begin
        mode_d = origin ? mode_e'(mode_cfg) : mode_q;
        sat_d  = sat_q;
        if (origin)
            sat_d = '0;
        else if (clamp && (sat_q != '1))
            sat_d = sat_q + 16'd1;
    end

    assign de_out      = de_q;
    assign x_out       = x_q;
    assign y_out       = y_q;
    assign r_out       = pix_q[3*PW-1:2*PW];
    assign g_out       = pix_q[2*PW-1:PW];
    assign b_out       = pix_q[PW-1:0];
    assign mode_active = mode_q;
    assign sat_count   = sat_q;

endmodule

// File: tb/tb_conv3x3_filter.sv
// Randomised raster-frame bench for conv3x3_filter, checked against an array-based
// reference that applies the kernels directly to the stored frame.
module tb_conv3x3_filter;
    localparam int H  = 8;
    localparam int V  = 6;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          de_in = 1'b0;
    logic [9:0]    x_in = '0, y_in = '0;
    logic [PW-1:0] r_in = '0, g_in = '0, b_in = '0;
    logic [1:0]    mode_cfg = '0;
    logic          de_out;
    logic [9:0]    x_out, y_out;
    logic [PW-1:0] r_out, g_out, b_out;
    logic [1:0]    mode_active;
    logic [15:0]   sat_count;

    always #5 clk = ~clk;

    conv3x3_filter #(.H_RES(H), .V_RES(V), .PW(PW)) dut (
        .clk(clk), .reset(reset),
        .de_in(de_in), .x_in(x_in), .y_in(y_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .mode_cfg(mode_cfg),
        .de_out(de_out), .x_out(x_out), .y_out(y_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .mode_active(mode_active), .sat_count(sat_count)
    );

    typedef struct { int de; int x; int y; int r; int g; int b; } exp_t;

    exp_t expq[$];
    int   fr[3][V][H];
    int   got_r[V][H];
    int   model_mode = 0;
    int   model_sat  = 0;
    int   kind = 0, flat_val = 0;
    int   n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int ref_kern(input int ch, input int x, input int y, input int m, output bit sat);
        int w[9];
        int s, maxv;
        maxv = (1 << PW) - 1;
        s = 0;
        sat = 0;
        case (m)
            1:       w = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
            2:       w = '{1, 1, 1, 1, 8, 1, 1, 1, 1};
            default: w = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
        endcase
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                s += w[dy*3+dx] * fr[ch][y-2+dy][x-2+dx];
        if (m != 3) return s / 16;
        if (s < 0)    begin sat = 1; return 0;    end
        if (s > maxv) begin sat = 1; return maxv; end
        return s;
    endfunction

    function automatic int pv(input int x, input int y);
        if (kind == 1) return flat_val;
        if (kind == 2) return (x == 3 && y == 3) ? 15 : 0;
        return int'($urandom_range(15));
    endfunction

    // One clock: check the output belonging to the input two cycles back, then drive a new input.
    task automatic cycle(input bit de, input int x, input int y, input int r, input int g, input int b, input int m);
        exp_t e;
        bit   s0, s1, s2, img;
        @(negedge clk);
        if (expq.size() == 2) begin
            e = expq.pop_front();
            check("de_out", de_out, e.de);
            check("x_out",  x_out,  e.x);
            check("y_out",  y_out,  e.y);
            check("r_out",  r_out,  e.r);
            check("g_out",  g_out,  e.g);
            check("b_out",  b_out,  e.b);
            if (e.de != 0 && e.x < H && e.y < V) got_r[e.y][e.x] = r_out;
        end
        check("mode_active", mode_active, model_mode);

        de_in = de; x_in = 10'(x); y_in = 10'(y);
        r_in = PW'(r); g_in = PW'(g); b_in = PW'(b); mode_cfg = 2'(m);

        img = de && x < H && y < V;
        if (img) begin
            fr[0][y][x] = r; fr[1][y][x] = g; fr[2][y][x] = b;
            if (x == 0 && y == 0) begin
                model_mode = m;
                model_sat  = 0;
            end
        end
        e = '{0, 0, 0, 0, 0, 0};
        if (de) begin
            e = '{1, x, y, r, g, b};
            if (img && x >= 2 && y >= 2 && model_mode != 0) begin
                e.r = ref_kern(0, x, y, model_mode, s0);
                e.g = ref_kern(1, x, y, model_mode, s1);
                e.b = ref_kern(2, x, y, model_mode, s2);
                if ((s0 | s1 | s2) && model_sat < 65535) model_sat++;
            end
        end
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic junk(input int m);
        cycle(0, int'($urandom_range(12)), int'($urandom_range(8)),
              int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)), m);
    endtask

    // Raster frame with two blanking pixels (de=1, x>=H) and one de=0 cycle per line.
    task automatic run_frame(input int m0, input int m1, input int sw_x, input int sw_y,
                             input int gap_x, input int gap_y, input bit rand_gaps, input int max_pix);
        int n, m, pr, pg, pb;
        n = 0;
        m = m0;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                got_r[y][x] = -1;
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                if (x == sw_x && y == sw_y) m = m1;
                if (x == gap_x && y == gap_y) repeat (3) junk(m);
                if (rand_gaps && $urandom_range(3) == 0) junk(m);
                if (n == max_pix) return;
                pr = pv(x, y); pg = pv(x, y); pb = pv(x, y);
                cycle(1, x, y, pr, pg, pb, m);
                n++;
            end
            cycle(1, H, y, int'($urandom_range(15)), int'($urandom_range(15)), int'($urandom_range(15)), m);
            cycle(1, H + 1, y, int'($urandom_range(15)), 3, 9, m);
            junk(m);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_de"},   de_out, 0);
        check({tag, "_x"},    x_out, 0);
        check({tag, "_y"},    y_out, 0);
        check({tag, "_r"},    r_out, 0);
        check({tag, "_g"},    g_out, 0);
        check({tag, "_b"},    b_out, 0);
        check({tag, "_mode"}, mode_active, 0);
        check({tag, "_sat"},  sat_count, 0);
    endtask

    initial begin
        // pixels driven while reset is held must not leak to the outputs
        repeat (4) begin
            @(negedge clk);
            de_in = 1'b1; x_in = '0; y_in = '0; mode_cfg = 2'b01;
            r_in = PW'($urandom_range(15)); g_in = PW'($urandom_range(15)); b_in = PW'($urandom_range(15));
            #1 check_reset_outputs("in_reset");
        end
        @(negedge clk);
        de_in = 1'b0;
        reset = 1'b1;

        kind = 0; run_frame(1, 1, -1, -1, -1, -1, 1, -1);
        kind = 1; flat_val = 5; run_frame(1, 1, -1, -1, -1, -1, 1, -1);

        kind = 2; run_frame(1, 1, -1, -1, -1, -1, 0, -1);
        idle(3);
        check("gauss_4_4", got_r[4][4], 3);
        check("gauss_5_4", got_r[4][5], 1);
        check("gauss_5_5", got_r[5][5], 0);
        check("gauss_1_1", got_r[1][1], 0);

        run_frame(3, 3, -1, -1, -1, -1, 0, -1);
        idle(3);
        check("sharp_4_4", got_r[4][4], 15);
        check("sharp_5_4", got_r[4][5], 0);
        check("sharp_4_5", got_r[5][4], 0);
        check("sharp_sat_const", sat_count, 5);
        check("sharp_sat_model", sat_count, model_sat);

        kind = 0; run_frame(1, 3, 4, 2, -1, -1, 1, -1);
        idle(3);
        check("mode_held", mode_active, 1);
        run_frame(3, 3, -1, -1, -1, -1, 1, -1);
        idle(3);
        check("mode_next", mode_active, 3);
        check("rand_sat", sat_count, model_sat);

        kind = 1; flat_val = 7; run_frame(2, 2, -1, -1, 5, 3, 0, -1);
        idle(3);
        check("box_2_2", got_r[2][2], 7);
        check("box_5_3", got_r[3][5], 7);
        check("box_7_5", got_r[5][7], 7);

        kind = 0; run_frame(3, 3, -1, -1, -1, -1, 1, 20);
        @(negedge clk);
        reset = 1'b0;
        #1 check_reset_outputs("mid_reset");
        expq.delete();
        model_mode = 0;
        model_sat  = 0;
        de_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_frame(2, 2, -1, -1, -1, -1, 1, -1);
        run_frame(3, 3, -1, -1, -1, -1, 0, -1);
        idle(3);
        check("post_reset_sat", sat_count, model_sat);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
